// File: rtl/rstseq02.sv
// Reset sequencer for the per-clock reset synchronizer bank: holds selected domains
// in reset for a minimum time, then releases them one at a time in ascending order.
module rstseq02 #(
    parameter int NDOM    = 2,
    parameter int CNTW    = 8,
    parameter int PORHOLD = 16,
    parameter int PORGAP  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            scanmode,
    input  logic            swrst,
    input  logic [NDOM-1:0] swmsk,
    input  logic [CNTW-1:0] hold,
    input  logic [CNTW-1:0] gap,
    output logic [NDOM-1:0] rstmsk,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSERT,
        S_RELEASE,
        S_GAP,
        S_DONE
    } state_t;

    state_t          r_state, w_state_nx;
    logic [CNTW-1:0] r_cnt, w_cnt_nx;
    logic [CNTW-1:0] r_hold, w_hold_nx;
    logic [CNTW-1:0] r_gap, w_gap_nx;
    logic [NDOM-1:0] r_left, w_left_nx;
    logic [NDOM-1:0] r_pend, w_pend_nx;
    logic [NDOM-1:0] r_msk, w_msk_nx;
    logic            r_busy, w_busy_nx;
    logic            r_done, w_done_nx;
    logic            w_start;
    logic [NDOM-1:0] w_start_msk;
    logic            w_release;
    logic [NDOM-1:0] w_low;

    function automatic logic [CNTW-1:0] f_hold_eff(input logic [CNTW-1:0] h);
        f_hold_eff = (h == '0) ? CNTW'(1) : h;
    endfunction

    // Lowest domain still waiting for release in the current sequence.
    assign w_low = r_left & (~r_left + NDOM'(1));

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_hold_nx   = r_hold;
        w_gap_nx    = r_gap;
        w_left_nx   = r_left;
        w_msk_nx    = r_msk;
        w_busy_nx   = r_busy;
        w_done_nx   = 1'b0;
        w_pend_nx   = r_pend | ((swrst && (r_state != S_IDLE)) ? swmsk : '0);
        w_start     = 1'b0;
        w_start_msk = '0;
        w_release   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (swrst && (swmsk != '0)) begin
                    w_start     = 1'b1;
                    w_start_msk = swmsk;
                end
            end
            S_ASSERT: begin
                if (r_cnt == f_hold_eff(r_hold)) w_release = 1'b1;
                else                             w_cnt_nx  = r_cnt + CNTW'(1);
            end
            S_GAP: begin
                if (r_cnt == r_gap) w_release = 1'b1;
                else                w_cnt_nx  = r_cnt + CNTW'(1);
            end
            S_RELEASE: begin
                // Last domain already released; one cycle later report completion.
                w_state_nx = S_DONE;
                w_busy_nx  = 1'b0;
                w_done_nx  = 1'b1;
            end
            S_DONE: begin
                if (w_pend_nx != '0) begin
                    w_start     = 1'b1;
                    w_start_msk = w_pend_nx;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        if (w_release) begin
            w_msk_nx   = r_msk & ~w_low;
            w_left_nx  = r_left & ~w_low;
            w_cnt_nx   = '0;
            w_state_nx = (w_left_nx == '0) ? S_RELEASE : S_GAP;
        end

        // Counter starts at 1 so that release lands exactly max(hold,1) edges after start.
        if (w_start) begin
            w_state_nx = S_ASSERT;
            w_left_nx  = w_start_msk;
            w_msk_nx   = r_msk | w_start_msk;
            w_hold_nx  = hold;
            w_gap_nx   = gap;
            w_cnt_nx   = CNTW'(1);
            w_busy_nx  = 1'b1;
            w_pend_nx  = '0;
        end
    end

    // Reset parks the FSM in ASSERT with count 0, so the first edge after reset acts as start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ASSERT;
            r_cnt   <= '0;
            r_hold  <= CNTW'(PORHOLD);
            r_gap   <= CNTW'(PORGAP);
            r_left  <= '1;
            r_pend  <= '0;
            r_msk   <= '1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_hold  <= w_hold_nx;
            r_gap   <= w_gap_nx;
            r_left  <= w_left_nx;
            r_pend  <= w_pend_nx;
            r_msk   <= w_msk_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

    assign rstmsk = scanmode ? '0 : r_msk;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_rstseq02.sv
// Directed bench for rstseq02: power-on, soft, queued, reset-abort and scan cases
// with hand-derived expected outputs per clock edge.
module tb_rstseq02;

    logic       clk;
    logic       rst;
    logic       scanmode;
    logic       swrst;
    logic [1:0] swmsk;
    logic [7:0] hold;
    logic [7:0] gap;
    logic [1:0] rstmsk;
    logic       busy;
    logic       done;

    int n_chk;
    int n_pass;

    rstseq02 #(
        .NDOM   (2),
        .CNTW   (8),
        .PORHOLD(16),
        .PORGAP (4)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .scanmode(scanmode),
        .swrst   (swrst),
        .swmsk   (swmsk),
        .hold    (hold),
        .gap     (gap),
        .rstmsk  (rstmsk),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Power-on sequence: first tick is P0; releases at P16 and P21, done at P22.
    task automatic por_seq(input string tag);
        logic [1:0] em;
        for (int k = 0; k <= 25; k++) begin
            tick();
            em = (k < 16) ? 2'b11 : (k < 21) ? 2'b10 : 2'b00;
            chk_eq($sformatf("%s_msk_P%0d", tag, k), 32'(rstmsk), 32'(em));
            chk_eq($sformatf("%s_busy_P%0d", tag, k), 32'(busy), 32'(k < 22));
            chk_eq($sformatf("%s_done_P%0d", tag, k), 32'(done), 32'(k == 22));
        end
    endtask

    initial begin
        logic [1:0] em;
        n_chk    = 0;
        n_pass   = 0;
        rst      = 1'b1;
        scanmode = 1'b0;
        swrst    = 1'b0;
        swmsk    = 2'b00;
        hold     = 8'd0;
        gap      = 8'd0;

        repeat (5) tick();
        chk_eq("rst_msk", 32'(rstmsk), 32'(2'b11));
        chk_eq("rst_busy", 32'(busy), 32'd1);
        chk_eq("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        por_seq("por");

        // Soft reset, both domains, hold=3 gap=2.
        swrst = 1'b1; swmsk = 2'b11; hold = 8'd3; gap = 8'd2;
        tick();
        swrst = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) tick();
            em = (k < 3) ? 2'b11 : (k < 6) ? 2'b10 : 2'b00;
            chk_eq($sformatf("soft_msk_E%0d", k), 32'(rstmsk), 32'(em));
            chk_eq($sformatf("soft_busy_E%0d", k), 32'(busy), 32'(k < 7));
            chk_eq($sformatf("soft_done_E%0d", k), 32'(done), 32'(k == 7));
        end

        // Single upper domain with hold=0 (treated as 1) and gap=0.
        swrst = 1'b1; swmsk = 2'b10; hold = 8'd0; gap = 8'd0;
        tick();
        swrst = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) tick();
            em = (k < 1) ? 2'b10 : 2'b00;
            chk_eq($sformatf("one_msk_E%0d", k), 32'(rstmsk), 32'(em));
            chk_eq($sformatf("one_busy_E%0d", k), 32'(busy), 32'(k < 2));
            chk_eq($sformatf("one_done_E%0d", k), 32'(done), 32'(k == 2));
        end

        // Empty-mask request is ignored.
        swrst = 1'b1; swmsk = 2'b00;
        tick();
        swrst = 1'b0;
        chk_eq("empty_busy0", 32'(busy), 32'd0);
        chk_eq("empty_msk0", 32'(rstmsk), 32'(2'b00));
        tick();
        chk_eq("empty_busy1", 32'(busy), 32'd0);
        chk_eq("empty_done1", 32'(done), 32'd0);

        // Queued request: domain 1 requested at E2 while domain 0 runs with hold=4;
        // hold changed to 2 before the queued sequence starts.
        swrst = 1'b1; swmsk = 2'b01; hold = 8'd4; gap = 8'd0;
        tick();
        swrst = 1'b0;
        for (int k = 0; k <= 11; k++) begin
            if (k > 0) tick();
            if (k == 2) begin
                swrst = 1'b0;
                hold  = 8'd2;
            end
            em = (k < 4) ? 2'b01 : (k < 6) ? 2'b00 : (k < 8) ? 2'b10 : 2'b00;
            chk_eq($sformatf("q_msk_E%0d", k), 32'(rstmsk), 32'(em));
            chk_eq($sformatf("q_busy_E%0d", k), 32'(busy), 32'((k < 5) || (k >= 6 && k < 9)));
            chk_eq($sformatf("q_done_E%0d", k), 32'(done), 32'((k == 5) || (k == 9)));
            if (k == 1) begin
                swrst = 1'b1;
                swmsk = 2'b10;
            end
        end

        // Scan mode forces the mask low without disturbing sequence timing.
        swrst = 1'b1; swmsk = 2'b11; hold = 8'd5; gap = 8'd1;
        tick();
        swrst = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) tick();
            if (k == 1) scanmode = 1'b1;
            if (k == 3) scanmode = 1'b0;
            #1;
            em = scanmode ? 2'b00 : (k < 5) ? 2'b11 : (k < 7) ? 2'b10 : 2'b00;
            chk_eq($sformatf("scan_msk_E%0d", k), 32'(rstmsk), 32'(em));
            chk_eq($sformatf("scan_busy_E%0d", k), 32'(busy), 32'(k < 8));
            chk_eq($sformatf("scan_done_E%0d", k), 32'(done), 32'(k == 8));
        end

        // Reset during GAP with a request pending; pending must be discarded.
        swrst = 1'b1; swmsk = 2'b11; hold = 8'd1; gap = 8'd5;
        tick();
        swrst = 1'b0;
        chk_eq("abort_msk_E0", 32'(rstmsk), 32'(2'b11));
        tick();
        chk_eq("abort_msk_E1", 32'(rstmsk), 32'(2'b10));
        swrst = 1'b1; swmsk = 2'b01;
        tick();
        swrst = 1'b0;
        rst   = 1'b1;
        tick();
        chk_eq("abort_rst_msk", 32'(rstmsk), 32'(2'b11));
        chk_eq("abort_rst_busy", 32'(busy), 32'd1);
        chk_eq("abort_rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        por_seq("abort_por");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rstseq02.md
# rstseq02

Reset sequencer feeding the per-clock reset synchronizer bank (`rstsyn02`/`rstsyn01`). It drives the `rstmsk` vector that holds individual clock domains in reset. It enforces a minimum assert time, then releases domains one at a time in ascending index order with a programmable gap between releases. It also serves software soft-reset requests on any subset of domains, queuing a request that arrives while a sequence is running.

## Interface
- `NDOM`, 2, number of reset domains (width of mask vectors); ≥1
- `CNTW`, 8, width of hold/gap counters and config inputs
- `PORHOLD`, 16, hold cycles used for the power-on sequence
- `PORGAP`, 4, gap cycles used for the power-on sequence
- `clk`  in  1  single clock; all logic is on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `scanmode`  in  1  1 = force `rstmsk` to all-0 combinationally; the FSM keeps running
- `swrst`  in  1  soft-reset request, sampled each cycle while 1
- `swmsk`  in  NDOM  domains selected by `swrst`
- `hold`  in  CNTW  assert time in cycles for soft sequences; quasi-static; 0 is treated as 1
- `gap`  in  CNTW  extra cycles between consecutive releases for soft sequences; quasi-static
- `rstmsk`  out  NDOM  1 = domain held in reset; connects to the `rstmsk` input of `rstsyn02`
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle pulse when a sequence completes

## Operation
- States: IDLE, ASSERT, RELEASE, GAP, DONE.
- Reset (`rst`=1):
  - `rstmsk` = all-1, `busy`=1, `done`=0, pending = 0.
  - State = ASSERT with selection = all domains, hold = PORHOLD, gap = PORGAP.
  - The power-on sequence runs automatically once `rst` falls.
- Sequence start (from IDLE with `swrst`=1 and `swmsk`≠0, or from DONE with pending≠0):
  - Latch the selection mask, `hold` and `gap`.
  - Set the selected `rstmsk` bits to 1; unselected bits keep their value (normally 0).
  - `busy`=1.
- A request with `swmsk`=0 in IDLE is ignored.
- ASSERT: count max(hold,1) cycles, then release the lowest selected domain.
- RELEASE/GAP:
  - Each release clears one `rstmsk` bit.
  - The next selected domain is cleared gap+1 cycles later.
  - Unselected indices consume no cycles.
- After the last release: DONE for one cycle (`done`=1, `busy`=0), then IDLE. If pending≠0, DONE starts the pending sequence instead.
- `swrst`=1 in any state other than IDLE: pending |= `swmsk`. Pending clears when its sequence starts, and that sequence uses the `hold`/`gap` values present at its start.
- A domain being released by the current sequence and also pending is re-asserted when the pending sequence starts.
- `rst` mid-sequence: immediately returns to the reset state above and discards pending.
- Counters are CNTW bits. No wrap occurs, because counts stop at their terminal value. The domain index is clog2(NDOM) bits.

## Timing
- Soft request sampled at edge E0 (IDLE, `swrst`=1):
  - `rstmsk` selected bits and `busy` are 1 from E0.
  - First selected domain is cleared at E0+max(hold,1).
  - k-th subsequent selected domain is cleared at E0+max(hold,1)+k·(gap+1).
- If the last release is at edge L:
  - `done`=1 for the cycle after edge L+1.
  - `busy`=0 from L+1.
  - A pending sequence starts at L+2, with `rstmsk` re-asserted at L+2.
- Power-on: edge P0 is the first edge with `rst`=0 and is treated as E0 with PORHOLD/PORGAP and all domains selected.
- All outputs are registered, except the `scanmode` gating of `rstmsk`.

## Test plan
- Power-on, NDOM=2, PORHOLD=16, PORGAP=4: hold `rst` 5 cycles, then drop it → `rstmsk`=11 through P15, `rstmsk[0]`=0 at P16, `rstmsk[1]`=0 at P21, `done` pulse at P22, `busy`=0 from P22.
- Soft reset, `hold`=3, `gap`=2, `swmsk`=11, pulse at E0 → `rstmsk`=11 at E0, 10 at E3, 00 at E6, `done` at E7.
- Single domain and edge config: `swmsk`=10, `hold`=0, `gap`=0 → `rstmsk`=10 at E0, 00 at E1, `done` at E2. Also check a `swmsk`=00 request → no state change, `busy` stays 0.
- Queued request:
  - Stimulus: `swmsk`=01 sequence running with `hold`=4; `swrst` with `swmsk`=10 at E2.
  - Response: `rstmsk[0]` cleared at E4, `done` at E5, new sequence at E6 with `rstmsk`=10, cleared at E6+hold.
- Reset mid-sequence: assert `rst` during GAP → next edge `rstmsk`=11, `busy`=1, pending=0, and a full power-on sequence runs after release.
- `scanmode`=1 during ASSERT → `rstmsk`=00 in the same cycle. When `scanmode` drops, `rstmsk` matches the FSM's true mask, and sequence timing is unchanged.
